// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM duty sequencer: waveform modes, FSM states, defaults.
package pwm_pkg;

    localparam int unsigned STEPS_DEFAULT = 36;
    localparam int unsigned IDX_W         = 6;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PRIME = 2'd1;
    localparam state_t ST_RUN   = 2'd2;

    typedef logic [1:0] mode_t;
    localparam mode_t MODE_MID  = 2'b00;
    localparam mode_t MODE_SINE = 2'b01;
    localparam mode_t MODE_TRI  = 2'b10;
    localparam mode_t MODE_USER = 2'b11;

endpackage

// File: rtl/pwm_sine_rom.sv
// Combinational step-index to duty lookup for one sine period of STEPS samples,
// centred on midscale; the table is built at elaboration and padded to 64 entries.
module pwm_sine_rom
    import pwm_pkg::*;
#(
    parameter int unsigned R     = 8,
    parameter int unsigned STEPS = STEPS_DEFAULT
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [R-1:0]     o_duty_c
);

    localparam real          PI    = 3.14159265358979323846;
    localparam real          FULL  = real'((64'd1 << R) - 64'd1);
    localparam int           MAXV  = int'((64'd1 << R) - 64'd1);
    localparam logic [R-1:0] MID   = {1'b1, {(R-1){1'b0}}};
    localparam int unsigned  DEPTH = 64;

    logic [R-1:0] w_rom [DEPTH];

    // Round half up, then clamp so the top code can never wrap.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        if (k < STEPS) begin : g_val
            localparam real VAL = FULL * (1.0 + $sin(2.0 * PI * real'(k) / real'(STEPS))) / 2.0 + 0.5;
            localparam int  Q   = $rtoi(VAL);
            localparam int  QS  = (Q > MAXV) ? MAXV : ((Q < 0) ? 0 : Q);
            assign w_rom[k] = R'(QS);
        end else begin : g_pad
            assign w_rom[k] = MID;
        end
    end

    assign o_duty_c = w_rom[i_idx];

endmodule

// File: rtl/pwm_duty_seq.sv
// Duty-word sequencer: steps through a waveform table, holding each step for N PWM
// periods, and hands each new duty word to the PWM stage with a one-cycle load pulse.
module pwm_duty_seq
    import pwm_pkg::*;
#(
    parameter int unsigned R     = 8,
    parameter int unsigned N     = 5,
    parameter int unsigned STEPS = STEPS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             period_end,
    input  logic [1:0]       mode,
    input  logic [R-1:0]     user_duty,
    output logic [R-1:0]     duty,
    output logic             duty_load,
    output logic [IDX_W-1:0] step_idx,
    output logic             cycle_done
);

    localparam logic [R-1:0]     MID      = {1'b1, {(R-1){1'b0}}};
    localparam logic [R-1:0]     FULL     = '1;
    localparam int unsigned      H        = STEPS / 2;
    localparam int unsigned      MW       = R + IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);
    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(N - 1);

    state_t           r_state, w_state_nxt;
    logic [R-1:0]     r_duty, w_duty_nxt;
    logic             r_load, w_load_nxt;
    logic             r_done, w_done_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [IDX_W-1:0] r_cnt, w_cnt_nxt;

    logic [IDX_W-1:0] w_f_idx;
    logic [R-1:0]     w_sine;
    logic [R-1:0]     w_tri;
    logic [R-1:0]     w_f;
    logic [MW-1:0]    w_tri_num;
    logic [MW-1:0]    w_tri_q;
    logic             w_step;

    // Index the waveform is evaluated at: 0 when priming, the next step when running.
    assign w_f_idx = (r_state == ST_RUN) ?
                     ((r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1)) : '0;
    assign w_step  = (r_cnt == LAST_CNT);

    pwm_sine_rom #(
        .R     (R),
        .STEPS (STEPS)
    ) u_sine_rom (
        .i_idx    (w_f_idx),
        .o_duty_c (w_sine)
    );

    // Triangle rises over the first half-cycle and mirrors back down.
    always_comb begin
        if (32'(w_f_idx) <= H) begin
            w_tri_num = MW'(w_f_idx) * MW'(FULL);
        end else begin
            w_tri_num = (MW'(STEPS) - MW'(w_f_idx)) * MW'(FULL);
        end
        w_tri_q = w_tri_num / MW'(H);
        w_tri   = (w_tri_q > MW'(FULL)) ? FULL : R'(w_tri_q);
    end

    always_comb begin
        case (mode)
            MODE_MID:  w_f = MID;
            MODE_SINE: w_f = w_sine;
            MODE_TRI:  w_f = w_tri;
            MODE_USER: w_f = user_duty;
            default:   w_f = MID;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_load_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        if (!en) begin
            // Disable overrides any coincident strobe.
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = MID;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_load_nxt  = (r_duty != MID);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_PRIME;
                end
                ST_PRIME: begin
                    if (period_end) begin
                        w_state_nxt = ST_RUN;
                        w_duty_nxt  = w_f;
                        w_load_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_RUN: begin
                    if (period_end) begin
                        if (w_step) begin
                            w_cnt_nxt  = '0;
                            w_idx_nxt  = w_f_idx;
                            w_duty_nxt = w_f;
                            w_load_nxt = 1'b1;
                            w_done_nxt = (r_idx == LAST_IDX);
                        end else begin
                            w_cnt_nxt = r_cnt + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_duty  <= MID;
            r_load  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_load  <= w_load_nxt;
            r_done  <= w_done_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign duty       = r_duty;
    assign duty_load  = r_load;
    assign step_idx   = r_idx;
    assign cycle_done = r_done;

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Directed bench for pwm_duty_seq: sine sequencing with N=5, triangle with N=1,
// user duty, disable on a boundary strobe, and asynchronous reset mid-run.
module tb_pwm_duty_seq;
    import pwm_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       period_end;
    logic [7:0] user_duty;

    logic       en_a, en_b;
    logic [1:0] mode_a, mode_b;
    logic [7:0] duty_a, duty_b;
    logic       load_a, load_b;
    logic [5:0] idx_a, idx_b;
    logic       done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;
    int tri_tab [19];
    int exp_d;

    pwm_duty_seq #(.R(8), .N(5), .STEPS(36)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_a),
        .period_end (period_end),
        .mode       (mode_a),
        .user_duty  (user_duty),
        .duty       (duty_a),
        .duty_load  (load_a),
        .step_idx   (idx_a),
        .cycle_done (done_a)
    );

    pwm_duty_seq #(.R(8), .N(1), .STEPS(36)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_b),
        .period_end (period_end),
        .mode       (mode_b),
        .user_duty  (user_duty),
        .duty       (duty_b),
        .duty_load  (load_b),
        .step_idx   (idx_b),
        .cycle_done (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PWM period of 'gap' clocks ending in a strobe; returns just after the strobe edge.
    task automatic strobe(input int gap);
        repeat (gap - 1) tick();
        period_end = 1'b1;
        tick();
        period_end = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        tri_tab = '{0, 14, 28, 42, 56, 70, 85, 99, 113, 127,
                    141, 155, 170, 184, 198, 212, 226, 240, 255};
        rst_n      = 1'b0;
        en_a       = 1'b0;
        en_b       = 1'b0;
        period_end = 1'b0;
        mode_a     = MODE_SINE;
        mode_b     = MODE_TRI;
        user_duty  = 8'd50;
        repeat (2) tick();

        chk("rst_duty", 32'(duty_a), 32'd128);
        chk("rst_load", 32'(load_a), 32'd0);
        chk("rst_idx", 32'(idx_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_state", 32'(u_a.r_state), 32'(ST_IDLE));
        chk("rst_duty_b", 32'(duty_b), 32'd128);

        // Sine, N=5, strobe every 256 clocks for the first step.
        rst_n = 1'b1;
        en_a  = 1'b1;
        tick();
        chk("prime_state", 32'(u_a.r_state), 32'(ST_PRIME));
        chk("prime_noload", 32'(load_a), 32'd0);
        strobe(256);
        chk("first_duty", 32'(duty_a), 32'd128);
        chk("first_load", 32'(load_a), 32'd1);
        chk("first_idx", 32'(idx_a), 32'd0);
        chk("first_state", 32'(u_a.r_state), 32'(ST_RUN));
        tick();
        chk("load_drop", 32'(load_a), 32'd0);
        repeat (4) strobe(256);
        chk("midstep_idx", 32'(idx_a), 32'd0);
        chk("midstep_load", 32'(load_a), 32'd0);
        strobe(256);
        chk("step1_idx", 32'(idx_a), 32'd1);
        chk("step1_load", 32'(load_a), 32'd1);

        for (int s = 2; s <= 36; s++) begin
            repeat (5) strobe(4);
            chk("sine_idx", 32'(idx_a), 32'(s % 36));
            chk("sine_load", 32'(load_a), 32'd1);
            chk("sine_done", 32'(done_a), (s == 36) ? 32'd1 : 32'd0);
            case (s)
                9:  chk("sine_idx9", 32'(duty_a), 32'd255);
                18: chk("sine_idx18", 32'(duty_a), 32'd128);
                27: chk("sine_idx27", 32'(duty_a), 32'd0);
                36: chk("sine_wrap", 32'(duty_a), 32'd128);
                default: ;
            endcase
        end
        tick();
        chk("done_drop", 32'(done_a), 32'd0);

        // Asynchronous reset while running at idx 12.
        for (int s = 1; s <= 12; s++) repeat (5) strobe(4);
        chk("pre_rst_idx", 32'(idx_a), 32'd12);
        chk("pre_rst_duty", 32'(duty_a), 32'd238);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_duty", 32'(duty_a), 32'd128);
        chk("arst_idx", 32'(idx_a), 32'd0);
        chk("arst_load", 32'(load_a), 32'd0);
        chk("arst_state", 32'(u_a.r_state), 32'(ST_IDLE));
        tick();
        rst_n = 1'b1;
        tick();
        chk("reprime_state", 32'(u_a.r_state), 32'(ST_PRIME));
        strobe(4);
        chk("reprime_idx", 32'(idx_a), 32'd0);
        chk("reprime_duty", 32'(duty_a), 32'd128);
        chk("reprime_load", 32'(load_a), 32'd1);

        // User duty: mode and value take effect only at a load.
        mode_a    = MODE_USER;
        user_duty = 8'd50;
        repeat (4) strobe(4);
        chk("user_hold_duty", 32'(duty_a), 32'd128);
        chk("user_hold_load", 32'(load_a), 32'd0);
        strobe(4);
        chk("user50_duty", 32'(duty_a), 32'd50);
        chk("user50_idx", 32'(idx_a), 32'd1);
        repeat (2) strobe(4);
        user_duty = 8'd200;
        strobe(4);
        chk("user_mid_duty", 32'(duty_a), 32'd50);
        chk("user_mid_load", 32'(load_a), 32'd0);
        repeat (2) strobe(4);
        chk("user200_duty", 32'(duty_a), 32'd200);
        chk("user200_load", 32'(load_a), 32'd1);
        chk("user200_idx", 32'(idx_a), 32'd2);

        // Disable coinciding with a boundary strobe.
        repeat (4) strobe(4);
        repeat (3) tick();
        period_end = 1'b1;
        en_a       = 1'b0;
        tick();
        period_end = 1'b0;
        chk("dis_idx", 32'(idx_a), 32'd0);
        chk("dis_duty", 32'(duty_a), 32'd128);
        chk("dis_load", 32'(load_a), 32'd1);
        chk("dis_done", 32'(done_a), 32'd0);
        chk("dis_state", 32'(u_a.r_state), 32'(ST_IDLE));
        tick();
        chk("dis_load_drop", 32'(load_a), 32'd0);

        // Triangle, N=1: every strobe is a step boundary.
        en_b = 1'b1;
        tick();
        strobe(4);
        chk("tri_first_duty", 32'(duty_b), 32'd0);
        chk("tri_first_load", 32'(load_b), 32'd1);
        tick();
        chk("tri_load_drop", 32'(load_b), 32'd0);
        for (int k = 1; k <= 36; k++) begin
            strobe(4);
            exp_d = (k % 36 <= 18) ? tri_tab[k % 36] : tri_tab[36 - k];
            chk("tri_duty", 32'(duty_b), 32'(exp_d));
            chk("tri_idx", 32'(idx_b), 32'(k % 36));
            chk("tri_load", 32'(load_b), 32'd1);
            chk("tri_done", 32'(done_b), (k == 36) ? 32'd1 : 32'd0);
        end
        chk("a_idle_duty", 32'(duty_a), 32'd128);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_duty_seq.md
PWM_DUTY_SEQ -- requirements
Module: pwm_duty_seq

Interface
REQ-001 Parameter R, default 8: width of the duty word, matching the downstream PWM counter width.
REQ-002 Parameter N, default 5: number of PWM periods each step is held; legal range 1..63.
REQ-003 Parameter STEPS, default 36: number of steps per waveform cycle; legal range 2..64.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  level; 1 runs the sequencer, 0 returns it to idle.
REQ-007 period_end  input  1  one-cycle strobe from the PWM stage, high in the cycle its counter equals 2**R-1.
REQ-008 mode  input  2  waveform select: 00 midscale hold, 01 sine, 10 triangle, 11 user duty.
REQ-009 user_duty  input  R  duty value used in mode 11.
REQ-010 duty  output  R  registered duty word that drives the PWM stage compare input.
REQ-011 duty_load  output  1  one-cycle pulse, high in the first cycle that a new duty value is presented.
REQ-012 step_idx  output  6  current step index, 0..STEPS-1.
REQ-013 cycle_done  output  1  one-cycle pulse when step_idx wraps from STEPS-1 to 0.

Function
REQ-014 FSM states: IDLE, PRIME, RUN.
REQ-015 IDLE: duty=2**(R-1), step_idx=0, period counter=0; en=1 moves the FSM to PRIME on the next edge.
REQ-016 PRIME: the first period_end loads duty=f(mode,0), pulses duty_load, clears the period counter, and moves the FSM to RUN.
REQ-017 RUN: each period_end increments the period counter; a period_end with counter==N-1 is a step boundary.
REQ-018 Step boundary: the counter clears, step_idx advances modulo STEPS, duty=f(mode,new idx), and duty_load pulses.
REQ-019 Latency: duty and duty_load change on the clock edge after the qualifying period_end, never at any other time while en=1.
REQ-020 Wrap: step_idx changing from STEPS-1 to 0 pulses cycle_done in the same cycle as duty_load.
REQ-021 f(mode,k), mode 00: 2**(R-1).
REQ-022 f(mode,k), mode 01: round((2**R-1)*(1+sin(2*pi*k/STEPS))/2), taken from the sine ROM.
REQ-023 f(mode,k), mode 10: floor(k*(2**R-1)/H) for k<=H, otherwise floor((STEPS-k)*(2**R-1)/H), where H=STEPS/2.
REQ-024 f(mode,k), mode 11: user_duty sampled at the boundary cycle.
REQ-025 mode and user_duty changes take effect only at the next load (PRIME or step boundary).
REQ-026 en=0 in any state: the FSM goes to IDLE on the next edge with IDLE values; duty_load pulses once if duty changed.
REQ-027 en=0 coinciding with period_end: en wins, and no step advance occurs.
REQ-028 N=1: every period_end in RUN is a step boundary.
REQ-029 Arithmetic is unsigned; duty saturates at 2**R-1 and never overflows.

Reset
REQ-030 rst_n=0 asynchronously forces the FSM to IDLE, duty=2**(R-1), step_idx=0, duty_load=0, cycle_done=0, and the period counter to 0.
REQ-031 Reset release is synchronous to clk; the first possible load is at the first period_end after PRIME is entered.

Structure
REQ-032 Shared package pwm_pkg holds the mode encodings, the FSM state type, and STEPS defaults.
REQ-033 Sub-module pwm_sine_rom, parameterised by R and STEPS: a combinational index-to-duty lookup implementing REQ-022.
REQ-034 Triangle values are computed in this block; no second ROM is used.

Verification
REQ-035 R=8, N=5, mode 01, en=1, period_end every 256 clk -> first load duty=128; step_idx advances every 5 strobes; idx 9 -> 255, idx 18 -> 128, idx 27 -> 0.
REQ-036 mode 01, run 36 steps -> cycle_done pulses once, together with duty_load, when step_idx goes 35 -> 0, and duty=128.
REQ-037 mode 10, N=1 -> duty sequence 0, 14, 28, ..., 255 at idx 18, then 240, ...; one duty_load per period_end.
REQ-038 mode 11, user_duty changed from 50 to 200 mid-step -> duty stays 50 until the next boundary, then becomes 200.
REQ-039 en dropped in the same cycle as a boundary period_end -> no advance; next cycle duty=128, step_idx=0, state IDLE.
REQ-040 rst_n asserted mid-RUN at idx 12 -> outputs return to reset values immediately, without waiting for a clk edge; after release, re-priming starts at idx 0.
